// File: rtl/oven_disp_pkg.sv
// rtl/oven_disp_pkg.sv - shared types and constants for the oven display controller
package oven_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [5:0] BLANK_CODE = 6'h3F;
    localparam logic [6:0] MAX_MINS   = 7'd99;
    localparam logic [6:0] MAX_SECS   = 7'd59;
    localparam int         CONV_STEPS = 7;

    function automatic logic [6:0] sat7(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 7-bit sequential double-dabble binary to two-digit BCD engine
module bin2bcd_seq
    import oven_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // {tens, ones, remaining binary}; binary bits shift up into the BCD nibbles
    logic [14:0] sr_q;
    logic [14:0] sr_adj;
    logic [14:0] sr_nxt;
    logic [2:0]  step_q;
    logic        run_q;

    always_comb begin
        sr_adj = sr_q;
        if (sr_q[14:11] >= 4'd5) sr_adj[14:11] = sr_q[14:11] + 4'd3;
        if (sr_q[10:7]  >= 4'd5) sr_adj[10:7]  = sr_q[10:7]  + 4'd3;
        sr_nxt = sr_adj << 1;
    end

    // done and the result are combinational so the caller can latch the
    // finished digits on the same edge that performs the final step
    assign done = run_q && (step_q == 3'(CONV_STEPS - 1));
    assign tens = sr_nxt[14:11];
    assign ones = sr_nxt[10:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            sr_q   <= {8'h00, bin};
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            sr_q   <= sr_nxt;
            step_q <= step_q + 3'd1;
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sevseg.sv
// rtl/sevseg.sv - active-low seven-segment decoder, {g..a}, codes 0-9, all others blank
module sevseg (
    input  logic [5:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (code)
            6'd0: seg = 7'b1000000;
            6'd1: seg = 7'b1111001;
            6'd2: seg = 7'b0100100;
            6'd3: seg = 7'b0110000;
            6'd4: seg = 7'b0011001;
            6'd5: seg = 7'b0010010;
            6'd6: seg = 7'b0000010;
            6'd7: seg = 7'b1111000;
            6'd8: seg = 7'b0000000;
            6'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/oven_display_ctrl.sv
// rtl/oven_display_ctrl.sv - MM:SS multiplexed display sequencer with BCD conversion, blink and colon
module oven_display_ctrl
    import oven_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] mins,
    input  logic [5:0] secs,
    input  logic       blink_en,
    input  logic       colon_en,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);

    state_t state_q;
    state_t state_d;
    logic   start;
    logic   conv_done;

    logic       m_done;
    logic       s_done;
    logic [3:0] m_tens_n;
    logic [3:0] m_ones_n;
    logic [3:0] s_tens_n;
    logic [3:0] s_ones_n;

    logic [3:0] m_tens_q;
    logic [3:0] m_ones_q;
    logic [3:0] s_tens_q;
    logic [3:0] s_ones_q;

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [FW-1:0] frame_q;
    logic          phase_q;
    logic          slot_wrap;
    logic          frame_wrap;
    logic          blanked;
    logic [5:0]    digit_code;

    assign conv_done = m_done & s_done;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    start   = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (conv_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = (state_q == CONV);

    bin2bcd_seq u_conv_mins (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (sat7(mins, MAX_MINS)),
        .done  (m_done),
        .tens  (m_tens_n),
        .ones  (m_ones_n)
    );

    bin2bcd_seq u_conv_secs (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (sat7({1'b0, secs}, MAX_SECS)),
        .done  (s_done),
        .tens  (s_tens_n),
        .ones  (s_ones_n)
    );

    // all four digits commit together so the display never shows a mix
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tens_q <= '0;
            m_ones_q <= '0;
            s_tens_q <= '0;
            s_ones_q <= '0;
        end else if (busy && conv_done) begin
            m_tens_q <= m_tens_n;
            m_ones_q <= m_ones_n;
            s_tens_q <= s_tens_n;
            s_ones_q <= s_ones_n;
        end
    end

    assign slot_wrap  = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_wrap = slot_wrap && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= slot_wrap ? '0 : presc_q + PW'(1);
            if (slot_wrap) idx_q <= idx_q + 2'd1;
            if (frame_wrap) begin
                if (frame_q == FW'(BLINK_DIV - 1)) begin
                    frame_q <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frame_q <= frame_q + FW'(1);
                end
            end
        end
    end

    assign blanked = blink_en && phase_q;

    always_comb begin
        digit_code = BLANK_CODE;
        case (idx_q)
            2'd0: digit_code = {2'b00, s_ones_q};
            2'd1: digit_code = {2'b00, s_tens_q};
            2'd2: digit_code = {2'b00, m_ones_q};
            2'd3: digit_code = (m_tens_q == 4'd0) ? BLANK_CODE : {2'b00, m_tens_q};
            default: digit_code = BLANK_CODE;
        endcase
    end

    sevseg u_sevseg (
        .code (digit_code),
        .seg  (seg)
    );

    assign an = blanked ? 4'b1111 : ~(4'b0001 << idx_q);
    assign dp = ~((idx_q == 2'd2) && colon_en && !blanked);

endmodule
